// File: rtl/lockstep_pkg.sv
// Purpose: shared types and LFSR step function for the on-chip lockstep equivalence checker.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package lockstep_pkg;

    // Checker run phases.
    typedef enum logic [2:0] {
        IDLE,
        DRST,
        REL,
        APPLY,
        WAIT,
        CMP,
        DONE
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (bit k holds the x^(k+1) term).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] shifted;
        shifted = {1'b0, s[31:1]};
        lfsr_next = s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lockstep_lfsr.sv
// Purpose: 32-bit Galois LFSR with synchronous seed reload and advance enable.
// Latency: new state visible one cycle after load/adv.
// Backpressure: none; adv simply holds the state when low.
module lockstep_lfsr
    import lockstep_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] state
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

    // Seed on reset or reload; otherwise step when asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED_NZ;
        end else if (load) begin
            state <= SEED_NZ;
        end else if (adv) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/design_lockstep_checker.sv
// Purpose: drives LFSR stimulus into two DUT copies, compares their settled responses, counts mismatches.
// Latency: run = RST_CYC + 1 + NUM_VECTORS*(SETTLE_CYC+1) cycles from the accepted start to done.
// Backpressure: none; start is ignored while busy. CHECKER_FAIL_CAPTURE_EN enables first-failure capture.
module design_lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          NUM_VECTORS = 1000,
    parameter int          SETTLE_CYC  = 2,
    parameter int          RST_CYC     = 2,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              dut_rst,
    output logic [DATA_W-1:0] stim_out,
    input  logic [DATA_W-1:0] resp_golden,
    input  logic [DATA_W-1:0] resp_netlist,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              fail_valid,
    output logic [CNT_W-1:0]  fail_vec,
    output logic [DATA_W-1:0] fail_golden,
    output logic [DATA_W-1:0] fail_netlist
);

    // Last timer value in each timed state, and the last vector index of a run.
    localparam logic [31:0] RST_LAST  = 32'(RST_CYC - 1);
    localparam logic [31:0] WAIT_LAST = (SETTLE_CYC > 1) ? 32'(SETTLE_CYC - 2) : 32'd0;
    localparam logic [31:0] VEC_LAST  = 32'(NUM_VECTORS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] tmr;
    logic [31:0] vec_idx;     // run-length counter, independent of the CNT_W-wide report
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_adv;
    logic        start_go;
    logic        miss;

    assign lfsr_adv = lfsr_next(lfsr_q);
    assign miss     = (resp_golden != resp_netlist);

    lockstep_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_go),
        .adv   (state == APPLY),
        .state (lfsr_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        dut_rst   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        start_go  = 1'b0;
        case (state)
            IDLE: begin
                dut_rst = 1'b1;
                if (start) begin
                    state_nxt = DRST;
                    start_go  = 1'b1;
                end
            end
            DRST: begin
                dut_rst = 1'b1;
                busy    = 1'b1;
                if (tmr == RST_LAST) begin
                    state_nxt = REL;
                end
            end
            REL: begin
                busy      = 1'b1;
                state_nxt = APPLY;
            end
            APPLY: begin
                busy      = 1'b1;
                state_nxt = (SETTLE_CYC > 1) ? WAIT : CMP;
            end
            WAIT: begin
                busy = 1'b1;
                if (tmr == WAIT_LAST) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                busy      = 1'b1;
                state_nxt = (vec_idx == VEC_LAST) ? DONE : APPLY;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = DRST;
                    start_go  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign pass = done && (mismatch_cnt == '0);

    // Dwell timer: restarts on every state change, counts only in the timed states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= 32'd0;
        end else if (state_nxt != state) begin
            tmr <= 32'd0;
        end else if (state == DRST || state == WAIT) begin
            tmr <= tmr + 32'd1;
        end
    end

    // Stimulus register: zero while the DUTs are held in reset, new LFSR word per vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_out <= '0;
        end else if (start_go) begin
            stim_out <= '0;
        end else if (state == APPLY) begin
            stim_out <= lfsr_adv[DATA_W-1:0];
        end
    end

    // Vector and mismatch counters; the mismatch count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx      <= 32'd0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (start_go) begin
            vec_idx      <= 32'd0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (state == CMP) begin
            vec_idx <= vec_idx + 32'd1;
            vec_cnt <= vec_cnt + CNT_W'(1);
            if (miss && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CHECKER_FAIL_CAPTURE_EN
    // First-failure capture: latched on the first mismatching compare of a run only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid   <= 1'b0;
            fail_vec     <= '0;
            fail_golden  <= '0;
            fail_netlist <= '0;
        end else if (start_go) begin
            fail_valid   <= 1'b0;
            fail_vec     <= '0;
            fail_golden  <= '0;
            fail_netlist <= '0;
        end else if ((state == CMP) && miss && !fail_valid) begin
            fail_valid   <= 1'b1;
            fail_vec     <= vec_cnt;
            fail_golden  <= resp_golden;
            fail_netlist <= resp_netlist;
        end
    end
`else
    assign fail_valid   = 1'b0;
    assign fail_vec     = '0;
    assign fail_golden  = '0;
    assign fail_netlist = '0;
`endif

endmodule

// File: tb/tb_design_lockstep_checker.sv
module tb_design_lockstep_checker;

    localparam int          NV   = 1000;
    localparam int          SET  = 2;
    localparam int          RSTC = 2;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int          NVS  = 20;
    localparam int          CWS  = 4;

    typedef struct {
        int          vec;
        int          mis;
        bit          pass;
        bit          fv;
        int          fvec;
        logic [31:0] fg;
        logic [31:0] fn;
        longint      done_cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    longint      cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // main instance
    logic        dut_rst, busy, done, pass, fail_valid;
    logic [31:0] stim_out, resp_golden, resp_netlist, fail_golden, fail_netlist;
    logic [15:0] vec_cnt, mismatch_cnt, fail_vec;
    logic [31:0] cmask [0:NV-1];

    // small saturating instance
    logic        dut_rst_s, busy_s, done_s, pass_s, fail_valid_s;
    logic [31:0] stim_s, fail_golden_s, fail_netlist_s;
    logic [31:0] netlist_s = 32'h0;
    logic [CWS-1:0] vec_cnt_s, mis_s, fail_vec_s;

    res_t        res_q[$];
    res_t        res_s_q[$];
    logic [31:0] stim_q[$];

    assign resp_golden  = stim_out;
    assign resp_netlist = stim_out ^ ((int'(vec_cnt) < NV) ? cmask[vec_cnt] : 32'h0);

    design_lockstep_checker #(
        .DATA_W(32), .NUM_VECTORS(NV), .SETTLE_CYC(SET), .RST_CYC(RSTC),
        .LFSR_SEED(SEED), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .stim_out(stim_out),
        .resp_golden(resp_golden), .resp_netlist(resp_netlist), .busy(busy), .done(done),
        .pass(pass), .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt), .fail_valid(fail_valid),
        .fail_vec(fail_vec), .fail_golden(fail_golden), .fail_netlist(fail_netlist)
    );

    design_lockstep_checker #(
        .DATA_W(32), .NUM_VECTORS(NVS), .SETTLE_CYC(SET), .RST_CYC(RSTC),
        .LFSR_SEED(SEED), .CNT_W(CWS)
    ) u_small (
        .clk(clk), .rst(rst), .start(start_s), .dut_rst(dut_rst_s), .stim_out(stim_s),
        .resp_golden(stim_s), .resp_netlist(netlist_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .vec_cnt(vec_cnt_s), .mismatch_cnt(mis_s), .fail_valid(fail_valid_s),
        .fail_vec(fail_vec_s), .fail_golden(fail_golden_s), .fail_netlist(fail_netlist_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR: polynomial given by its exponent list, Galois right shift.
    function automatic logic [31:0] model_step(input logic [31:0] s);
        int          exps[4] = '{32, 22, 2, 1};
        logic [31:0] poly = 32'h0;
        foreach (exps[i]) poly[exps[i]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    // mode 0: loopback, 1: bit 0 flipped on vector 5, 2: random corruptions
    task automatic plan_run(input int mode);
        logic [31:0] s;
        res_t        r;
        int          n_bad;
        int          idx;
        logic [31:0] m;
        for (int i = 0; i < NV; i++) cmask[i] = 32'h0;
        if (mode == 1) cmask[5] = 32'h1;
        if (mode == 2) begin
            n_bad = $urandom_range(1, 6);
            for (int k = 0; k < n_bad; k++) begin
                idx = $urandom_range(0, NV - 1);
                m = $urandom;
                if (m == 0) m = 32'h1;
                cmask[idx] = m;
            end
        end
        s = SEED;
        r.mis = 0; r.fv = 0; r.fvec = 0; r.fg = 0; r.fn = 0;
        for (int i = 0; i < NV; i++) begin
            s = model_step(s);
            stim_q.push_back(s);
            if (cmask[i] != 0) begin
                if (!r.fv) begin
                    r.fv = 1; r.fvec = i; r.fg = s; r.fn = s ^ cmask[i];
                end
                r.mis++;
            end
        end
        r.vec  = NV;
        r.pass = (r.mis == 0);
`ifndef CHECKER_FAIL_CAPTURE_EN
        r.fv = 0; r.fvec = 0; r.fg = 0; r.fn = 0;
`endif
        r.done_cyc = cyc + 1 + RSTC + 1 + NV * (SET + 1);
        res_q.push_back(r);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic plan_small();
        logic [31:0] s;
        res_t        r;
        s = SEED;
        r.mis = 0; r.fv = 0; r.fvec = 0; r.fg = 0; r.fn = 0;
        for (int i = 0; i < NVS; i++) begin
            s = model_step(s);
            if (s != 32'h0) begin
                if (!r.fv) begin
                    r.fv = 1; r.fvec = i; r.fg = s; r.fn = 32'h0;
                end
                if (r.mis < (1 << CWS) - 1) r.mis++;
            end
        end
        r.vec  = NVS % (1 << CWS);
        r.pass = 0;
`ifndef CHECKER_FAIL_CAPTURE_EN
        r.fv = 0; r.fvec = 0; r.fg = 0; r.fn = 0;
`endif
        r.done_cyc = cyc + 1 + RSTC + 1 + NVS * (SET + 1);
        res_s_q.push_back(r);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_dut_rst", dut_rst, 1);
        chk("rst_stim", stim_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_mismatch", mismatch_cnt, 0);
        chk("rst_fail_valid", fail_valid, 0);
        chk("rst_fail_vec", fail_vec, 0);
        chk("rst_fail_golden", fail_golden, 0);
        chk("rst_fail_netlist", fail_netlist, 0);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < NV * (SET + 1) + RSTC + 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_vec(input int k);
        bit seen = 0;
        for (int i = 0; i < NV * (SET + 1) + RSTC + 20; i++) begin
            @(posedge clk); #1;
            if (int'(vec_cnt) == k) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("vec_timeout", 0, 1);
    endtask

    // Per-vector stimulus check and end-of-run check for the main instance.
    logic [15:0] prev_vec = 0;
    logic        prev_done = 0;
    always @(negedge clk) begin
        res_t        r;
        logic [31:0] e;
        if (rst) begin
            prev_vec  = 0;
            prev_done = 0;
        end else begin
            if (vec_cnt != prev_vec && vec_cnt != 0) begin
                if (stim_q.size() == 0) chk("stim_q_underflow", 1, 0);
                else begin
                    e = stim_q.pop_front();
                    chk("stim", stim_out, e);
                end
            end
            prev_vec = vec_cnt;
            if (done && !prev_done) begin
                if (res_q.size() == 0) chk("res_q_underflow", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("done_cycle", cyc, r.done_cyc);
                    chk("vec_cnt", vec_cnt, r.vec);
                    chk("mismatch_cnt", mismatch_cnt, r.mis);
                    chk("pass", pass, r.pass);
                    chk("busy_at_done", busy, 0);
                    chk("dut_rst_at_done", dut_rst, 0);
                    chk("fail_valid", fail_valid, r.fv);
                    chk("fail_vec", fail_vec, r.fvec);
                    chk("fail_golden", fail_golden, r.fg);
                    chk("fail_netlist", fail_netlist, r.fn);
                end
            end
            prev_done = done;
        end
    end

    // End-of-run check for the saturating instance.
    logic prev_done_s = 0;
    always @(negedge clk) begin
        res_t r;
        if (rst) prev_done_s = 0;
        else begin
            if (done_s && !prev_done_s) begin
                if (res_s_q.size() == 0) chk("res_s_q_underflow", 1, 0);
                else begin
                    r = res_s_q.pop_front();
                    chk("s_done_cycle", cyc, r.done_cyc);
                    chk("s_vec_cnt", vec_cnt_s, r.vec);
                    chk("s_mismatch_sat", mis_s, r.mis);
                    chk("s_pass", pass_s, r.pass);
                    chk("s_fail_valid", fail_valid_s, r.fv);
                    chk("s_fail_vec", fail_vec_s, r.fvec);
                    chk("s_fail_golden", fail_golden_s, r.fg);
                    chk("s_fail_netlist", fail_netlist_s, r.fn);
                end
            end
            prev_done_s = done_s;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NV; i++) cmask[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_dut_rst", dut_rst, 1);

        // Loopback run alongside the saturation run on the small instance.
        fork
            plan_run(0);
            plan_small();
        join
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", done, 1);
        chk("pass_held", pass, 1);
        chk("small_done_held", done_s, 1);

        // Single flipped bit on vector 5; start from DONE clears done/pass next cycle.
        plan_run(1);
        chk("restart_done_clr", done, 0);
        chk("restart_pass_clr", pass, 0);
        chk("restart_busy", busy, 1);
        chk("restart_dut_rst", dut_rst, 1);
        chk("restart_stim_zero", stim_out, 0);
        wait_done();

        // Random corruptions plus start pulses dropped into WAIT.
        plan_run(2);
        for (int k = 0; k < 3; k++) begin
            wait_vec(100 + 250 * k + int'($urandom_range(0, 50)));
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_after_ignored_start", busy, 1);
        end
        wait_done();

        // Same seed again, then abort at vector 400.
        plan_run(0);
        wait_vec(400);
        rst = 1'b1;
        stim_q.delete();
        res_q.delete();
        #2;
        chk_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        plan_run(0);
        wait_done();

        repeat (4) @(posedge clk);
        #1;
        chk("res_q_drained", res_q.size(), 0);
        chk("stim_q_drained", stim_q.size(), 0);
        chk("res_s_q_drained", res_s_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
